// File: rtl/bounce_pkg.sv
// bounce_pkg: shared FSM state, velocity type, reset-value helpers and parameter checks for bounce_engine
package bounce_pkg;
  typedef enum logic [1:0] {IDLE, UPD, DONE} state_t;
  localparam int VEL_W_DEF = 4;
  typedef logic signed [VEL_W_DEF-1:0] vel_t;
  function automatic int x_rst(int i, int sz);
    return 2 * sz * i;
  endfunction
  function automatic int y_rst(int i, int sz);
    return sz * i;
  endfunction
  function automatic int v_rst(int i);
    return i + 1;
  endfunction
  function automatic bit params_ok(int n_obj, int vel_w, int xw, int yw, int h, int v, int sz);
    return n_obj >= 1 && n_obj <= 7 && n_obj <= (1 << (vel_w - 1)) - 1 &&
           sz < h && sz < v && (h - sz) < (1 << xw) && (v - sz) < (1 << yw);
  endfunction
endpackage

// File: rtl/bounce_axis.sv
// bounce_axis: combinational single-axis step that clamps to [0,lim] and reflects velocity on contact
module bounce_axis #(
  parameter int PW    = 10,
  parameter int VEL_W = 4,
  parameter int NW    = 12
) (
  input  logic [PW-1:0]           p,
  input  logic signed [VEL_W-1:0] v,
  input  logic [PW-1:0]           lim,
  output logic [PW-1:0]           p_n,
  output logic signed [VEL_W-1:0] v_n,
  output logic                    hit
);
  logic signed [NW-1:0] n, m;
  // widen position and velocity so under/overflow past either wall is visible as a sign or magnitude
  always_comb begin
    n   = $signed({{(NW-PW){1'b0}}, p}) + $signed({{(NW-VEL_W){v[VEL_W-1]}}, v});
    m   = $signed({{(NW-PW){1'b0}}, lim});
    hit = (n <= 0) || (n >= m);
    p_n = (n <= 0) ? '0 : (n >= m) ? lim : n[PW-1:0];
    v_n = hit ? -v : v;
  end
endmodule

// File: rtl/bounce_engine.sv
// bounce_engine: per-frame sequential sweep moving N_OBJ bouncing sprites; BOUNCE_GRAVITY_EN adds downward acceleration
module bounce_engine
  import bounce_pkg::*;
#(
  parameter int N_OBJ    = 4,
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int VEL_W    = 4,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int OBJ_SIZE = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       frame_tick,
  input  logic                       pause,
  input  logic [$clog2(N_OBJ+1)-1:0] rd_idx,
  output logic [XW-1:0]              rd_x,
  output logic [YW-1:0]              rd_y,
  output logic                       busy,
  output logic [N_OBJ-1:0]           hit_mask,
  output logic                       hit_pulse
);
  localparam int IW = $clog2(N_OBJ + 1);
  localparam int NW = (XW > YW ? XW : YW) + 2;
  localparam logic [XW-1:0] XMAX = XW'(H_ACTIVE - OBJ_SIZE);
  localparam logic [YW-1:0] YMAX = YW'(V_ACTIVE - OBJ_SIZE);

  if (!params_ok(N_OBJ, VEL_W, XW, YW, H_ACTIVE, V_ACTIVE, OBJ_SIZE)) begin : g_bad_params
    $error("bounce_engine: illegal parameter combination");
  end

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [XW-1:0]           x_q [N_OBJ];
  logic [XW-1:0]           x_d [N_OBJ];
  logic [YW-1:0]           y_q [N_OBJ];
  logic [YW-1:0]           y_d [N_OBJ];
  logic signed [VEL_W-1:0] vx_q [N_OBJ];
  logic signed [VEL_W-1:0] vx_d [N_OBJ];
  logic signed [VEL_W-1:0] vy_q [N_OBJ];
  logic signed [VEL_W-1:0] vy_d [N_OBJ];
  logic [N_OBJ-1:0]        hit_mask_q, hit_mask_d;
  logic                    hit_pulse_q, hit_pulse_d;
  logic [XW-1:0]           cx, nx;
  logic [YW-1:0]           cy, ny;
  logic signed [VEL_W-1:0] cvx, cvy, vy_in, nvx, nvy;
  logic                    hx, hy;

  // fetch the sprite addressed by the sweep index into the shared datapath
  always_comb begin
    cx  = '0;
    cy  = '0;
    cvx = '0;
    cvy = '0;
    for (int i = 0; i < N_OBJ; i++)
      if (idx_q == IW'(i)) begin
        cx  = x_q[i];
        cy  = y_q[i];
        cvx = vx_q[i];
        cvy = vy_q[i];
      end
  end

`ifdef BOUNCE_GRAVITY_EN
  localparam logic signed [VEL_W-1:0] VMAX = {1'b0, {(VEL_W-1){1'b1}}};
  assign vy_in = (cvy == VMAX) ? cvy : cvy + 1'b1;
`else
  assign vy_in = cvy;
`endif

  bounce_axis #(.PW(XW), .VEL_W(VEL_W), .NW(NW)) u_axis_x (
    .p(cx), .v(cvx), .lim(XMAX), .p_n(nx), .v_n(nvx), .hit(hx)
  );
  bounce_axis #(.PW(YW), .VEL_W(VEL_W), .NW(NW)) u_axis_y (
    .p(cy), .v(vy_in), .lim(YMAX), .p_n(ny), .v_n(nvy), .hit(hy)
  );

  // sweep sequencing: start on an accepted tick, write back one sprite per cycle, pulse on completion
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    x_d         = x_q;
    y_d         = y_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    hit_mask_d  = hit_mask_q;
    hit_pulse_d = 1'b0;
    case (state_q)
      IDLE: if (frame_tick && ena && !pause) begin
        state_d    = UPD;
        idx_d      = '0;
        hit_mask_d = '0;
      end
      UPD: begin
        for (int i = 0; i < N_OBJ; i++)
          if (idx_q == IW'(i)) begin
            x_d[i]        = nx;
            y_d[i]        = ny;
            vx_d[i]       = nvx;
            vy_d[i]       = nvy;
            hit_mask_d[i] = hx | hy;
          end
        idx_d       = idx_q + 1'b1;
        state_d     = (idx_q == IW'(N_OBJ - 1)) ? DONE : UPD;
        hit_pulse_d = (idx_q == IW'(N_OBJ - 1)) && |hit_mask_d;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state registers with the spread-out starting formation as reset value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      hit_mask_q  <= '0;
      hit_pulse_q <= 1'b0;
      for (int i = 0; i < N_OBJ; i++) begin
        x_q[i]  <= XW'(x_rst(i, OBJ_SIZE));
        y_q[i]  <= YW'(y_rst(i, OBJ_SIZE));
        vx_q[i] <= VEL_W'(v_rst(i));
        vy_q[i] <= VEL_W'(v_rst(i));
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hit_mask_q  <= hit_mask_d;
      hit_pulse_q <= hit_pulse_d;
      x_q         <= x_d;
      y_q         <= y_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
    end
  end

  // renderer read port; out-of-range indices read as the origin
  always_comb begin
    rd_x = '0;
    rd_y = '0;
    for (int i = 0; i < N_OBJ; i++)
      if (rd_idx == IW'(i)) begin
        rd_x = x_q[i];
        rd_y = y_q[i];
      end
  end

  assign busy      = state_q != IDLE;
  assign hit_mask  = hit_mask_q;
  assign hit_pulse = hit_pulse_q;
endmodule

// File: tb/tb_bounce_engine.sv
// tb_bounce_engine: scoreboard bench; stimulus queues expected sprite snapshots, monitor checks them at sweep end or on request
module tb_bounce_engine;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic       frame_tick = 1'b0;
  logic       pause = 1'b0;
  logic       snap = 1'b0;
  logic [2:0] rd_idx = 3'd0;
  logic [9:0] rd_x, rd_y;
  logic       busy;
  logic [3:0] hit_mask;
  logic       hit_pulse;
  int tests = 0;
  int fails = 0;

  typedef struct {
    string          nm;
    logic [3:0][9:0] x;
    logic [3:0][9:0] y;
    int             mask;
    int             pul;
    int             bc;
  } exp_t;
  exp_t q[$];

  always #10 clk = ~clk;

  bounce_engine dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .frame_tick(frame_tick), .pause(pause),
    .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .busy(busy),
    .hit_mask(hit_mask), .hit_pulse(hit_pulse)
  );

  // k sweeps of free flight from the reset formation; sprite 3 touches the floor (464) on sweep 104
  function automatic exp_t mk(string nm, int k, int pul, int bc);
    exp_t e;
    e.nm = nm;
    for (int i = 0; i < 4; i++) begin
      e.x[i] = 10'(32 * i + (i + 1) * k);
      e.y[i] = (k == 105 && i == 3) ? 10'd460 : 10'(16 * i + (i + 1) * k);
    end
    e.mask = (k == 104) ? 8 : 0;
    e.pul  = pul;
    e.bc   = bc;
    return e;
  endfunction

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  initial begin : monitor
    logic bprev;
    int   bcnt, pcnt;
    exp_t e;
    bprev = 1'b0;
    bcnt  = 0;
    pcnt  = 0;
    forever begin
      @(negedge clk);
      if (busy) bcnt++;
      if (hit_pulse) pcnt++;
      if ((bprev && !busy) || snap) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: output presented with no pending expectation");
        end else begin
          e = q.pop_front();
          for (int i = 0; i < 4; i++) begin
            rd_idx = 3'(i);
            #1;
            chk($sformatf("%s x%0d", e.nm, i), int'(rd_x), int'(e.x[i]));
            chk($sformatf("%s y%0d", e.nm, i), int'(rd_y), int'(e.y[i]));
          end
          rd_idx = 3'd4;
          #1;
          chk($sformatf("%s x4", e.nm), int'(rd_x), 0);
          chk($sformatf("%s y4", e.nm), int'(rd_y), 0);
          chk($sformatf("%s busy_cycles", e.nm), bcnt, e.bc);
          chk($sformatf("%s hit_pulses", e.nm), pcnt, e.pul);
          chk($sformatf("%s hit_mask", e.nm), int'(hit_mask), e.mask);
          chk($sformatf("%s busy", e.nm), int'(busy), 0);
        end
        bcnt = 0;
        pcnt = 0;
      end
      bprev = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  task automatic snapit();
    @(posedge clk);
    #1 snap = 1'b1;
    @(posedge clk);
    #1 snap = 1'b0;
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
  endtask

  initial begin : stimulus
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    q.push_back(mk("reset", 0, 0, 0));
    snapit();
    q.push_back(mk("tick1", 1, 0, 5));
    tick();
    settle();
    q.push_back(mk("ignored_tick", 2, 0, 5));
    tick();
    @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    settle();
    q.push_back(mk("pause_gate", 2, 0, 0));
    pause = 1'b1;
    tick();
    settle();
    pause = 1'b0;
    snapit();
    q.push_back(mk("ena_gate", 2, 0, 0));
    ena = 1'b0;
    tick();
    settle();
    ena = 1'b1;
    snapit();
    q.push_back(mk("pause_mid", 3, 0, 5));
    tick();
    @(posedge clk);
    #1 pause = 1'b1;
    settle();
    pause = 1'b0;
    for (int k = 4; k <= 105; k++) begin
      q.push_back(mk($sformatf("sweep%0d", k), k, (k == 104) ? 1 : 0, 5));
      tick();
      settle();
      if (k == 104) begin
        q.push_back(mk("mask_hold", 104, 0, 0));
        repeat (3) @(posedge clk);
        snapit();
      end
    end
    q.push_back(mk("rst_mid", 0, 0, 2));
    tick();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    q.push_back(mk("post_rst", 0, 0, 0));
    snapit();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_expectations: got %0d unchecked, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bounce_engine.md
# bounce_engine

Multi-object motion engine for the bouncing-sprite VGA demo inside `tt_um_sjsu`. It holds position and velocity for `N_OBJ` square sprites and advances all of them once per video frame. Each sprite reflects off the four edges of the active area. Objects are processed one per clock in a sequential sweep, so only one axis-step datapath is needed. The pixel renderer reads positions through an indexed read port while the engine is idle.

## Interface

Parameters:
- `N_OBJ`, 4: number of sprites, 1..7, and must satisfy `N_OBJ ≤ 2^(VEL_W-1)-1`.
- `XW`, 10: x coordinate width (unsigned).
- `YW`, 10: y coordinate width (unsigned).
- `VEL_W`, 4: velocity width (two's complement).
- `H_ACTIVE`, 640: active width in pixels.
- `V_ACTIVE`, 480: active height in pixels.
- `OBJ_SIZE`, 16: sprite edge length in pixels.

Ports:
- `clk`, in, 1: system clock, one clock domain. All state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `ena`, in, 1: block enable. When low, new sweeps are not started.
- `frame_tick`, in, 1: single-cycle pulse at the start of vertical blanking.
- `pause`, in, 1: when high, new sweeps are not started.
- `rd_idx`, in, `$clog2(N_OBJ+1)`: sprite select for the read port.
- `rd_x`, out, `XW`: x of the selected sprite; 0 if `rd_idx ≥ N_OBJ`.
- `rd_y`, out, `YW`: y of the selected sprite; 0 if `rd_idx ≥ N_OBJ`.
- `busy`, out, 1: high while a sweep is in progress.
- `hit_mask`, out, `N_OBJ`: bit i is set if sprite i touched any wall in the last sweep.
- `hit_pulse`, out, 1: one-cycle pulse at the end of a sweep if `hit_mask` is nonzero.

## Operation

- Limits: `XMAX = H_ACTIVE-OBJ_SIZE`, `YMAX = V_ACTIVE-OBJ_SIZE`.
- Reset values for sprite i:
  - `x[i] = 2*OBJ_SIZE*i`, `y[i] = OBJ_SIZE*i`
  - `vx[i] = vy[i] = i+1`
  - `busy = 0`, `hit_mask = 0`, `hit_pulse = 0`, FSM in IDLE.
- FSM states are IDLE, UPD and DONE.
  - IDLE → UPD when `frame_tick & ena & ~pause`. The object index is set to 0 and `hit_mask` is cleared.
  - UPD processes sprite `idx`, then increments `idx`. After `idx == N_OBJ-1` it moves to DONE.
  - DONE drives `hit_pulse = |hit_mask` for one cycle, then returns to IDLE.
- Axis step, applied to each axis with its own limit:
  - Compute `n = p + v`, sign-extended to `max(XW,YW)+2` bits.
  - If `n ≤ 0`: set `p = 0`, `v = -v`, hit.
  - Else if `n ≥ MAX`: set `p = MAX`, `v = -v`, hit. Landing exactly on the limit counts as a hit.
  - Otherwise: `p = n`.
- Boundary rules:
  - A `frame_tick` arriving while `busy` is high is ignored, not queued.
  - Dropping `ena` or raising `pause` mid-sweep does not abort the sweep; it completes.
  - `rst_n` asserted mid-sweep restores every reset value immediately.
- The read port is combinational from the state registers. Values are consistent only while `busy` is low; the renderer reads only during active video.

## Timing

- Tick sampled on edge T: `busy` is high for cycles T+1..T+N_OBJ+1 (N_OBJ UPD cycles plus 1 DONE cycle).
- Sprite i is updated on edge T+1+i and is visible on `rd_x`/`rd_y` in the same cycle as that edge (combinational read).
- `hit_pulse` is high in cycle T+N_OBJ+1, which is the DONE cycle.
- `hit_mask` holds its value until the next sweep starts.

## Configuration

- `BOUNCE_GRAVITY_EN` defined:
  - In UPD, `vy` is incremented by 1 before the y step, saturating at `+2^(VEL_W-1)-1`.
  - The floor reflection uses the incremented velocity.
- Undefined: `vy` changes only through reflection, and its magnitude stays constant.

## Structure

- Package `bounce_pkg` holds:
  - FSM state enum
  - `vel_t` typedef
  - reset-value functions for x, y and velocity
  - parameter legality checks
- Sub-module `bounce_axis`: combinational single-axis reflect step. Inputs are `p`, `v` and `MAX`; outputs are new `p`, new `v` and `hit`. It is instantiated once for x and once for y.

## Test plan

All scenarios use default parameters, with `BOUNCE_GRAVITY_EN` undefined unless stated.

- **Reset:** `rd_idx=2` → `rd_x=64`, `rd_y=32`, `busy=0`, `hit_mask=0`; `rd_idx=4` → `rd_x=0`, `rd_y=0`.
- **Single tick:** sprite 0 moves (0,0)→(1,1) and sprite 3 moves (96,48)→(100,52). `busy` is high for exactly 5 cycles. `hit_pulse` stays low.
- **Floor bounce:** after 104 ticks, sprite 3 has `y=464`, `hit_mask=4'b1000` and `hit_pulse` fires once. After tick 105, `y=460`.
- **Ignored tick:** a second tick 2 cycles after the first → sprite 0 `x=1`, not 2.
- **Gating:**
  - `pause=1` during a tick → no state change and `busy` stays 0; same result for `ena=0`.
  - `pause` raised in UPD → the sweep still completes.
- **Reset mid-sweep:** `rst_n` low at T+2 → all reset values restored immediately, `busy=0`.
- **Gravity build (`BOUNCE_GRAVITY_EN` defined):** one tick → sprite 0 has `vy=2`, `y=2`.
